// File: rtl/lsu_mem_access.sv
// Load/store access stage: one op at a time from execute to data memory over req/gnt/rvalid.
// Optional LSU_MISALIGN_TRAP_EN completes misaligned half/word ops locally with misalign_o=1.

`ifndef ALU_OP_BUS
`define ALU_OP_BUS 7:0
`define ALU_ADD 8'h01
`define ALU_LB  8'h20
`define ALU_LH  8'h21
`define ALU_LW  8'h22
`define ALU_LBU 8'h23
`define ALU_LHU 8'h24
`define ALU_SB  8'h25
`define ALU_SH  8'h26
`define ALU_SW  8'h27
`endif

module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [`ALU_OP_BUS] alu_op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [`ALU_OP_BUS] alu_op_o,
  output logic [31:0]       read_offset_o,
  output logic [31:0]       rmem_data_o,
  output logic              bus_err_o,
  output logic              misalign_o
);

  localparam logic RST_ENABLE = 1'b0;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [29:0]       addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic              valid_q;
  logic [`ALU_OP_BUS] alu_op_q;
  logic [1:0]        off_q;
  logic [31:0]       rdata_q;
  logic              bus_err_q;
  logic              misalign_q;
  logic              is_load_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic [1:0]  off_d;
  logic        is_load_d;
  logic        is_store_d;
  logic        misalign_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  // Decode of the incoming op: strobes and lane-replicated data for the bus.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    off_d      = addr_i[1:0];
    is_load_d  = 1'b0;
    is_store_d = 1'b0;
    wstrb_d    = 4'b0000;
    wdata_d    = 32'h0;
    case (alu_op_i)
      `ALU_LB, `ALU_LBU, `ALU_LH, `ALU_LHU, `ALU_LW: is_load_d = 1'b1;
      `ALU_SB: begin
        is_store_d = 1'b1;
        wstrb_d    = 4'b0001 << off_d;
        wdata_d    = {4{wdata_i[7:0]}};
      end
      `ALU_SH: begin
        is_store_d = 1'b1;
        wstrb_d    = 4'b0011 << off_d;
        wdata_d    = {2{wdata_i[15:0]}};
      end
      `ALU_SW: begin
        is_store_d = 1'b1;
        wstrb_d    = 4'b1111;
        wdata_d    = wdata_i;
      end
      default: ;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    case (alu_op_i)
      `ALU_LH, `ALU_LHU, `ALU_SH: misalign_d = off_d[0];
      `ALU_LW, `ALU_SW:           misalign_d = |off_d;
      default:                    misalign_d = 1'b0;
    endcase
`else
    misalign_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst == RST_ENABLE) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      alu_op_q   <= '0;
      off_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      is_load_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            alu_op_q   <= alu_op_i;
            off_q      <= off_d;
            addr_q     <= addr_i[31:2];
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= misalign_d;
            is_load_q  <= is_load_d;
            wait_cnt_q <= '0;
            if ((is_load_d || is_store_d) && !misalign_d) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              we_q    <= is_store_d;
              wstrb_q <= wstrb_d;
              wdata_q <= wdata_d;
            end else begin
              // Non-memory or trapped op: complete without touching the bus.
              state_q <= RESP;
              valid_q <= 1'b1;
              we_q    <= 1'b0;
              wstrb_q <= '0;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state_q    <= WAIT;
            req_q      <= 1'b0;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        WAIT: begin
          // rvalid is checked first so a response on the timeout cycle still wins.
          if (mem_rvalid_i) begin
            rdata_q <= is_load_q ? mem_rdata_i : 32'h0;
            state_q <= RESP;
            valid_q <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_VAL)) begin
            bus_err_q <= 1'b1;
            state_q   <= RESP;
            valid_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = {addr_q, 2'b00};
  assign mem_wstrb_o   = wstrb_q;
  assign mem_wdata_o   = wdata_q;
  assign valid_o       = valid_q;
  assign alu_op_o      = alu_op_q;
  assign read_offset_o = {30'b0, off_q};
  assign rmem_data_o   = rdata_q;
  assign bus_err_o     = bus_err_q;
  assign misalign_o    = misalign_q;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access stage between execute and data memory; directly upstream of the load data expansion stage.
- Accepts one memory op at a time from execute and drives a req/gnt/rvalid handshake to data memory.
- Forms the word-aligned address, store byte strobes and lane-replicated store data.
- Returns raw read word, byte offset and op to the expansion/write-back path via valid/ready.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT before forced bus-error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (`RST_ENABLE` = 1'b0)
- valid_i  in  1  execute has an op
- ready_o  out  1  block can accept an op
- alu_op_i  in  `ALU_OP_BUS`  op code
- addr_i  in  32  byte address (execute result)
- wdata_i  in  32  store source register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  {addr[31:2], 2'b00}
- mem_wstrb_o  out  4  byte enables (0 for loads)
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid / store ack
- mem_rdata_i  in  32  read word
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- alu_op_o  out  `ALU_OP_BUS`  latched op
- read_offset_o  out  32  {30'b0, addr[1:0]}
- rmem_data_o  out  32  raw read word (0 for stores/non-mem ops)
- bus_err_o  out  1  timeout completion, qualified by valid_o
- misalign_o  out  1  misaligned completion, qualified by valid_o

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset → IDLE, all outputs 0, timeout counter 0.
- IDLE: ready_o=1. On valid_i: latch op, addr, wdata.
  - Mem op (LB/LH/LW/LBU/LHU/SB/SH/SW) → REQ.
  - Any other op → RESP with rmem_data_o=0 and no memory access.
- REQ: mem_req_o=1; addr/we/wstrb/wdata stay stable until mem_gnt_i. On gnt → WAIT, req drops the next cycle.
- WAIT: counter increments each cycle.
  - mem_rvalid_i: capture mem_rdata_i (loads only; stores capture 0) → RESP.
  - Counter == TIMEOUT_CYCLES (when nonzero) without rvalid: bus_err_o=1, rmem_data_o=0 → RESP.
  - rvalid arriving in the same cycle as the timeout wins; no error.
- RESP: valid_o=1; all result outputs stable until ready_i. On ready_i → IDLE; ready_o rises the following cycle.
- Minimum latency with gnt and rvalid each one cycle after request: accept at cycle 0, REQ 1, WAIT 2, valid_o at cycle 3.
- One op outstanding at a time. rvalid seen in IDLE/REQ/RESP is ignored.
- Strobes, with off = addr[1:0]:
  - SB: 4'b0001<<off; SH: 4'b0011<<off, truncated to 4 bits; SW: 4'b1111.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Loads: we=0, wstrb=0.
- Reset mid-operation (any state): synchronous return to IDLE, req/valid drop on that edge, latched data cleared.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, skip REQ/WAIT.
  - They go IDLE → RESP directly with misalign_o=1, rmem_data_o=0, no mem_req_o.
- Undefined:
  - misalign_o tied 0.
  - Misaligned ops are issued as normal with the truncated strobe (e.g. SH off 3 → wstrb 4'b1000).

Test Plan:
- LW addr 0x8000_0004, gnt and rvalid immediate, rdata 0xDEADBEEF → mem_addr_o 0x8000_0004, wstrb 0, valid_o at cycle 3, rmem_data_o 0xDEADBEEF, read_offset_o 0.
- SB addr 0x1003, wdata 0x000000A5 → mem_we_o=1, wstrb 4'b1000, wdata 0xA5A5A5A5, mem_addr_o 0x1000, rmem_data_o 0.
- LH addr 0x2002 with gnt stalled 3 cycles and ready_i low 2 cycles in RESP → req and addr held stable through the stall, outputs held stable, read_offset_o 2, one completion only.
- TIMEOUT_CYCLES=4, no rvalid → valid_o with bus_err_o=1 after 4 WAIT cycles. A second run with rvalid on cycle 4 → bus_err_o=0.
- rst low while in WAIT, then a late rvalid arrives → next cycle IDLE, ready_o=1, valid_o never asserted.
- With LSU_MISALIGN_TRAP_EN, SW addr 0x3001 → no mem_req_o, valid_o next cycle with misalign_o=1. Without the macro → wstrb 4'b1111 at 0x3000.
